// File: rtl/quad_decoder.sv
// quad_decoder: quadrature rotary-encoder front end.
//   Each encoder phase passes through a synchroniser. The synchronised pair
//   is debounced jointly and then decoded into a signed position count.
//   The count is either 2x (legacy) or 4x decoded, and it wraps or saturates.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset (release synchronous to clk)
//   a, b        raw encoder phases (asynchronous)
//   load        load value from load_value on this edge (beats a count)
//   load_value  value to load
//   clr_err     clear the sticky error flag
//   value       position count
//   step        one-cycle pulse per counted transition
//   dir         direction of last counted transition (1 = up)
//   err         sticky illegal (double-bit) transition flag
module quad_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned STEP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_err,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE);
  localparam logic [FW-1:0]  FILL_MAX = FW'(SYNC_STAGES);
  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  // Priming phase: FILL waits until the synchroniser holds real pin data,
  // ARM waits for the first debounced acceptance, RUN decodes.
  typedef enum logic [1:0] {PH_FILL, PH_ARM, PH_RUN} phase_t;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             s, s_prev, f;
  logic [CW-1:0]          cnt;
  logic [FW-1:0]          fill_cnt;
  phase_t                 phase;
  logic                   accept;

  // Registered transition presented to the decoder one cycle after f moves.
  logic                   dec_vld;
  logic [1:0]             d_old, d_new;

  logic                   up, dn, illegal;
  logic [WIDTH:0]         sum_up, diff_dn;
  logic [WIDTH-1:0]       val_up, val_dn;

  assign s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // s has been stable and different from f for DEBOUNCE counted cycles.
  assign accept = (s != f) && (s == s_prev) && (cnt == CNT_MAX);

  always_comb begin
    up      = 1'b0;
    dn      = 1'b0;
    illegal = 1'b0;
    if (dec_vld) begin
      if ((d_old ^ d_new) == 2'b11) begin
        illegal = 1'b1;
      end else if (MODE == 0) begin
        up = ({d_old, d_new} == 4'b0010) || ({d_old, d_new} == 4'b1101);
        dn = ({d_old, d_new} == 4'b0001) || ({d_old, d_new} == 4'b1110);
      end else begin
        up = {d_old, d_new} inside {4'b0010, 4'b1011, 4'b1101, 4'b0100};
        dn = {d_old, d_new} inside {4'b0001, 4'b0111, 4'b1110, 4'b1000};
      end
    end
  end

  // One extra bit carries the overflow / borrow used for clamping.
  always_comb begin
    sum_up  = {1'b0, value} + STEP_W;
    diff_dn = {1'b0, value} - STEP_W;
    val_up  = ((SATURATE != 0) && sum_up[WIDTH])  ? '1 : sum_up[WIDTH-1:0];
    val_dn  = ((SATURATE != 0) && diff_dn[WIDTH]) ? '0 : diff_dn[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      s_prev   <= '0;
      f        <= '0;
      cnt      <= '0;
      fill_cnt <= '0;
      phase    <= PH_FILL;
      dec_vld  <= 1'b0;
      d_old    <= '0;
      d_new    <= '0;
      value    <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      sync_a  <= {sync_a[SYNC_STAGES-2:0], a};
      sync_b  <= {sync_b[SYNC_STAGES-2:0], b};
      s_prev  <= s;
      dec_vld <= 1'b0;

      // Debounce: a change of s restarts the count; stability lets it run.
      if (s == f) begin
        cnt <= '0;
      end else if (s != s_prev) begin
        cnt <= CW'(1);
      end else if (cnt == CNT_MAX) begin
        f       <= s;
        cnt     <= '0;
        dec_vld <= (phase == PH_RUN);
        d_old   <= f;
        d_new   <= s;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // The synchroniser resets to 00, so the "pins at 00" shortcut is taken
      // on the first cycle its last stage carries sampled pin data.
      case (phase)
        PH_FILL: begin
          if (fill_cnt == FILL_MAX) begin
            phase <= (s == 2'b00) ? PH_RUN : PH_ARM;
          end else begin
            fill_cnt <= fill_cnt + FW'(1);
          end
        end
        PH_ARM: begin
          if (accept) begin
            phase <= PH_RUN;
          end
        end
        default: ;
      endcase

      step <= up | dn;
      if (up | dn) begin
        dir <= up;
      end

      if (load) begin
        value <= load_value;
      end else if (up) begin
        value <= val_up;
      end else if (dn) begin
        value <= val_dn;
      end

      if (illegal) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder. Four instances share the
// encoder pins: default 2x, 4x, and WIDTH=4/STEP=3 in wrap and saturate form.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b1;
  logic       b = 1'b1;
  logic       load = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] lv8 = '0;
  logic [3:0] lv4 = '0;

  logic [7:0] v0, v1;
  logic [3:0] vw, vs;
  logic       st0, st1, stw, sts;
  logic       d0, d1, dw, ds;
  logic       e0, e1, ew, es;

  int tests = 0;
  int fails = 0;
  int n0 = 0;
  int n1 = 0;
  int ns = 0;
  int snap;

  always #5 clk = ~clk;

  quad_decoder u_m0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(lv8),
    .clr_err(clr_err), .value(v0), .step(st0), .dir(d0), .err(e0)
  );

  quad_decoder #(.MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(lv8),
    .clr_err(clr_err), .value(v1), .step(st1), .dir(d1), .err(e1)
  );

  quad_decoder #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_wr (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(lv4),
    .clr_err(clr_err), .value(vw), .step(stw), .dir(dw), .err(ew)
  );

  quad_decoder #(.WIDTH(4), .STEP(3), .SATURATE(1)) u_sa (
    .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(lv4),
    .clr_err(clr_err), .value(vs), .step(sts), .dir(ds), .err(es)
  );

  always @(negedge clk) begin
    if (st0) n0++;
    if (st1) n1++;
    if (sts) ns++;
  end

  task automatic move(input logic [1:0] ab);
    @(negedge clk);
    {a, b} = ab;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] x8, input logic [3:0] x4);
    @(negedge clk);
    load = 1'b1;
    lv8  = x8;
    lv4  = x4;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL rst_value got=%0d exp=0", v0); end
    tests++; if ({st0, d0, e0} !== 3'b000) begin fails++; $display("FAIL rst_flags got=%b exp=000", {st0, d0, e0}); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL idle_value got=%0d exp=0", v0); end
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL idle_err got=%b exp=0", e0); end
    tests++; if (n0 !== 0) begin fails++; $display("FAIL idle_steps got=%0d exp=0", n0); end
    move(2'b01);
    tests++; if (v0 !== 8'd1) begin fails++; $display("FAIL first_up got=%0d exp=1", v0); end
    tests++; if (d0 !== 1'b1) begin fails++; $display("FAIL first_dir got=%b exp=1", d0); end
    tests++; if (n0 !== 1) begin fails++; $display("FAIL first_steps got=%0d exp=1", n0); end
    move(2'b00);
    move(2'b10);
    move(2'b11);
    tests++; if (v0 !== 8'd2) begin fails++; $display("FAIL detent_m0 got=%0d exp=2", v0); end
    tests++; if (n0 !== 2) begin fails++; $display("FAIL detent_steps got=%0d exp=2", n0); end
    tests++; if (v1 !== 8'd4) begin fails++; $display("FAIL detent_m1 got=%0d exp=4", v1); end
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL detent_err got=%b exp=0", e0); end
  endtask

  task automatic test_modes;
    move(2'b01);
    move(2'b00);
    do_load(8'd0, 4'd0);
    tests++; if ({v0, v1} !== 16'd0) begin fails++; $display("FAIL mode_load got=%0d/%0d exp=0/0", v0, v1); end
    for (int i = 0; i < 3; i++) begin
      move(2'b10); move(2'b11); move(2'b01); move(2'b00);
    end
    tests++; if (v0 !== 8'd6) begin fails++; $display("FAIL cw_m0 got=%0d exp=6", v0); end
    tests++; if (v1 !== 8'd12) begin fails++; $display("FAIL cw_m1 got=%0d exp=12", v1); end
    tests++; if (d0 !== 1'b1) begin fails++; $display("FAIL cw_dir got=%b exp=1", d0); end
    for (int i = 0; i < 3; i++) begin
      move(2'b01); move(2'b11); move(2'b10); move(2'b00);
    end
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL ccw_m0 got=%0d exp=0", v0); end
    tests++; if (v1 !== 8'd0) begin fails++; $display("FAIL ccw_m1 got=%0d exp=0", v1); end
    tests++; if ({d0, d1} !== 2'b00) begin fails++; $display("FAIL ccw_dir got=%b exp=00", {d0, d1}); end
  endtask

  task automatic test_debounce;
    snap = n0;
    @(negedge clk);
    a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL glitch_value got=%0d exp=0", v0); end
    tests++; if (n0 !== snap) begin fails++; $display("FAIL glitch_steps got=%0d exp=%0d", n0, snap); end
    @(negedge clk);
    a = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL lat_edge6 got=%0d exp=0", v0); end
    @(posedge clk);
    #1;
    tests++; if (v0 !== 8'd1) begin fails++; $display("FAIL lat_edge7 got=%0d exp=1", v0); end
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL lat_step got=%b exp=1", st0); end
    @(posedge clk);
    #1;
    tests++; if (st0 !== 1'b0) begin fails++; $display("FAIL lat_step_end got=%b exp=0", st0); end
    repeat (5) @(negedge clk);
    tests++; if (n0 !== snap + 1) begin fails++; $display("FAIL lat_steps got=%0d exp=%0d", n0, snap + 1); end
  endtask

  task automatic test_wrap_sat;
    move(2'b11);
    do_load(8'd14, 4'd14);
    move(2'b01);
    tests++; if (vw !== 4'd1) begin fails++; $display("FAIL wrap_up got=%0d exp=1", vw); end
    tests++; if (vs !== 4'd15) begin fails++; $display("FAIL sat_up got=%0d exp=15", vs); end
    tests++; if (v0 !== 8'd15) begin fails++; $display("FAIL w8_up got=%0d exp=15", v0); end
    move(2'b00);
    do_load(8'd1, 4'd1);
    snap = ns;
    move(2'b01);
    tests++; if (vw !== 4'd14) begin fails++; $display("FAIL wrap_dn got=%0d exp=14", vw); end
    tests++; if (vs !== 4'd0) begin fails++; $display("FAIL sat_dn got=%0d exp=0", vs); end
    tests++; if (ds !== 1'b0) begin fails++; $display("FAIL sat_dir got=%b exp=0", ds); end
    tests++; if (ns !== snap + 1) begin fails++; $display("FAIL sat_step got=%0d exp=%0d", ns, snap + 1); end
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL w8_dn got=%0d exp=0", v0); end
  endtask

  task automatic test_err_load;
    snap = n0;
    move(2'b10);
    tests++; if (e0 !== 1'b1) begin fails++; $display("FAIL illegal_err got=%b exp=1", e0); end
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL illegal_value got=%0d exp=0", v0); end
    tests++; if (n0 !== snap) begin fails++; $display("FAIL illegal_steps got=%0d exp=%0d", n0, snap); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL clr_err got=%b exp=0", e0); end
    @(negedge clk);
    {a, b} = 2'b01;
    repeat (7) @(posedge clk);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (e0 !== 1'b1) begin fails++; $display("FAIL clr_vs_illegal got=%b exp=1", e0); end
    @(negedge clk); clr_err = 1'b0;
    repeat (3) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL clr_err2 got=%b exp=0", e0); end
    move(2'b00);
    @(negedge clk);
    {a, b} = 2'b10;
    repeat (7) @(posedge clk);
    @(negedge clk);
    load = 1'b1;
    lv8  = 8'hA5;
    @(posedge clk);
    #1;
    tests++; if (v0 !== 8'hA5) begin fails++; $display("FAIL load_prio got=%h exp=a5", v0); end
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL load_step got=%b exp=1", st0); end
    tests++; if (d0 !== 1'b1) begin fails++; $display("FAIL load_dir got=%b exp=1", d0); end
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (v0 !== 8'hA5) begin fails++; $display("FAIL load_hold got=%h exp=a5", v0); end
  endtask

  task automatic test_reset_mid;
    move(2'b11);
    @(negedge clk);
    {a, b} = 2'b01;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL mid_value got=%0d exp=0", v0); end
    tests++; if ({st0, d0, e0} !== 3'b000) begin fails++; $display("FAIL mid_flags got=%b exp=000", {st0, d0, e0}); end
    {a, b} = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    snap = n0;
    repeat (20) @(negedge clk);
    tests++; if (v0 !== 8'd0) begin fails++; $display("FAIL prime_value got=%0d exp=0", v0); end
    tests++; if (n0 !== snap) begin fails++; $display("FAIL prime_steps got=%0d exp=%0d", n0, snap); end
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL prime_err got=%b exp=0", e0); end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_debounce;
    test_wrap_sat;
    test_err_load;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
